router_ctrl_fsm: RTL and testbench

Sequencing controller for the router's input-side datapath (header/parity register, synchronizer, three output FIFOs). It decodes the destination address of each incoming packet and waits when the target FIFO is busy. It then drives the register's state strobes through header, payload, FIFO-full stall and parity check, and raises busy to throttle the source. It is a Moore FSM with a latched destination address.

---
 rtl/router_pkg.sv | 47 ++++
 rtl/router_wait_timer.sv | 37 +++
 rtl/router_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_router_ctrl_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the router input-side controller: state encoding and strobe bundle.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a. Optional feature macro used by the controller: CTRL_TIMEOUT_EN.
package router_pkg;

  localparam logic [1:0] INVALID_ADDR = 2'b11;
  localparam int         NUM_FIFOS    = 3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic full_state;
    logic laf_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
  } ctrl_out_t;

  // Moore decode: every strobe is a pure function of the state.
  function automatic ctrl_out_t decode_state(state_t s);
    ctrl_out_t o;
    o               = '0;
    o.detect_add    = (s == DECODE_ADDRESS);
    o.lfd_state     = (s == LOAD_FIRST_DATA);
    o.ld_state      = (s == LOAD_DATA);
    o.full_state    = (s == FIFO_FULL_STATE);
    o.laf_state     = (s == LOAD_AFTER_FULL);
    o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
    o.write_enb_reg = (s == LOAD_FIRST_DATA) || (s == LOAD_DATA) ||
                      (s == LOAD_PARITY)     || (s == LOAD_AFTER_FULL);
    o.busy          = !((s == DECODE_ADDRESS) || (s == LOAD_DATA));
    return o;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Counts consecutive cycles the controller is held in WAIT_TILL_EMPTY; flags expiry.
// Latency: expired asserts combinationally on the TIMEOUT_CYCLES-th consecutive held cycle.
// Backpressure: none; any non-held cycle clears the count. Used only with CTRL_TIMEOUT_EN.
module router_wait_timer #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic hold,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = hold && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // advance while held, restart whenever the wait ends (including on expiry)
  always_comb begin
    cnt_d = '0;
    if (hold && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router input-side controller: decodes destination, sequences header/payload/stall/parity strobes.
// Latency: strobes are registered and follow the state one-for-one; lfd_state one cycle after the header.
// Backpressure: busy stalls the source in every state but DECODE_ADDRESS/LOAD_DATA. Macro: CTRL_TIMEOUT_EN.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int ADDR_W = 2
`ifdef CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 30
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [2:0]        fifo_empty,
  input  logic [2:0]        soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              full_state,
  output logic              laf_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
`ifdef CTRL_TIMEOUT_EN
  output logic              drop_pkt,
`endif
  output logic [ADDR_W-1:0] dest_addr
);

  localparam int NUM_SLOTS = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
  ctrl_out_t         out_q, out_d;

  // Pad the per-FIFO vectors so the invalid address indexes a constant 0.
  logic [NUM_SLOTS-1:0] empty_pad;
  logic [NUM_SLOTS-1:0] srst_pad;
  logic                 addr_ok;
  logic                 srst_hit;

  assign empty_pad = NUM_SLOTS'(fifo_empty);
  assign srst_pad  = NUM_SLOTS'(soft_reset);
  assign addr_ok   = (data_in != INVALID_ADDR);
  assign srst_hit  = srst_pad[dest_addr_q];

`ifdef CTRL_TIMEOUT_EN
  logic wait_hold;
  logic wait_expired;
  logic drop_pkt_q, drop_pkt_d;

  // held = would stay in WAIT_TILL_EMPTY this cycle absent a timeout
  assign wait_hold = (state_q == WAIT_TILL_EMPTY) && !empty_pad[dest_addr_q] && !srst_hit;

  router_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock   (clock),
    .resetn  (resetn),
    .hold    (wait_hold),
    .expired (wait_expired)
  );

  assign drop_pkt_d = wait_expired;
  assign drop_pkt   = drop_pkt_q;
`endif

  // next-state, destination capture and strobe pre-decode
  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    if ((state_q == DECODE_ADDRESS) && pkt_valid && addr_ok) begin
      dest_addr_d = data_in;
    end
    if (srst_hit) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok) begin
            state_d = empty_pad[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)           state_d = DECODE_ADDRESS;
          else if (low_packet_valid) state_d = LOAD_PARITY;
          else                       state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (empty_pad[dest_addr_q]) state_d = LOAD_FIRST_DATA;
`ifdef CTRL_TIMEOUT_EN
          else if (wait_expired)      state_d = DECODE_ADDRESS;
`endif
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
    // strobes registered from the next state so they line up with state_q
    out_d = decode_state(state_d);
  end

  // single state/output register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= DECODE_ADDRESS;
      dest_addr_q <= '0;
      out_q       <= decode_state(DECODE_ADDRESS);
`ifdef CTRL_TIMEOUT_EN
      drop_pkt_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
      out_q       <= out_d;
`ifdef CTRL_TIMEOUT_EN
      drop_pkt_q  <= drop_pkt_d;
`endif
    end
  end

  assign detect_add    = out_q.detect_add;
  assign lfd_state     = out_q.lfd_state;
  assign ld_state      = out_q.ld_state;
  assign full_state    = out_q.full_state;
  assign laf_state     = out_q.laf_state;
  assign rst_int_reg   = out_q.rst_int_reg;
  assign write_enb_reg = out_q.write_enb_reg;
  assign busy          = out_q.busy;
  assign dest_addr     = dest_addr_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Bench for router_ctrl_fsm: packets described at transaction level are expanded into
// per-cycle expected strobe traces, then replayed against the DUT (checked at negedge).
// Optional CTRL_TIMEOUT_EN section exercises the wait-till-empty abort.
module tb_router_ctrl_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [1:0] dest_addr;
`ifdef CTRL_TIMEOUT_EN
  logic       drop_pkt;
`endif

  int total = 0;
  int bad   = 0;

  router_ctrl_fsm dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .soft_reset       (soft_reset),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .full_state       (full_state),
    .laf_state        (laf_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .busy             (busy),
`ifdef CTRL_TIMEOUT_EN
    .drop_pkt         (drop_pkt),
`endif
    .dest_addr        (dest_addr)
  );

  // Expected strobe vectors {detect_add,lfd,ld,full,laf,rst_int,write_enb,busy}
  localparam logic [7:0] E_DEC  = 8'b1000_0000;
  localparam logic [7:0] E_LFD  = 8'b0100_0011;
  localparam logic [7:0] E_LD   = 8'b0010_0010;
  localparam logic [7:0] E_FULL = 8'b0001_0001;
  localparam logic [7:0] E_LAF  = 8'b0000_1011;
  localparam logic [7:0] E_LP   = 8'b0000_0011;
  localparam logic [7:0] E_CPE  = 8'b0000_0101;
  localparam logic [7:0] E_WAIT = 8'b0000_0001;

  typedef struct {
    logic       rstn;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pdone;
    logic       lpv;
    logic [7:0] exp;
    logic [1:0] exp_dest;
    logic       exp_drop;
  } cyc_t;

  cyc_t       trace[$];
  logic [1:0] m_dest = 2'd0;

  // A cycle whose don't-care inputs are random; soft reset never targets the selected FIFO.
  function automatic cyc_t noise(logic [7:0] expv);
    cyc_t       c;
    logic [2:0] mask;
    mask       = 3'b001 << m_dest;
    c.rstn     = 1'b1;
    c.pv       = 1'($urandom);
    c.din      = 2'($urandom);
    c.full     = 1'($urandom);
    c.empty    = 3'($urandom);
    c.srst     = 3'($urandom) & ~mask;
    c.pdone    = 1'($urandom);
    c.lpv      = 1'($urandom);
    c.exp      = expv;
    c.exp_dest = m_dest;
    c.exp_drop = 1'b0;
    return c;
  endfunction

  // Idle decode cycles: either no packet or a header with the invalid address.
  task automatic gen_idle(int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c      = noise(E_DEC);
      c.srst = 3'b000;
      if ($urandom_range(0, 1) == 1) begin
        c.pv  = 1'b1;
        c.din = 2'b11;
      end else begin
        c.pv = 1'b0;
      end
      trace.push_back(c);
    end
  endtask

  // One packet: w wait cycles, len payload cycles, optional full stall before payload k
  // of f cycles with lafx choosing the exit (0 resume, 1 low_packet_valid, 2 parity_done).
  // abort: 0 soft reset in first payload cycle, 1 hard reset there, 2 full at parity check.
  task automatic gen_packet(int dest, int w, int len, bit stall, int k, int f, int lafx, int abort);
    cyc_t c;
    bit   to_parity;
    c             = noise(E_DEC);
    c.srst        = 3'b000;
    c.pv          = 1'b1;
    c.din         = 2'(dest);
    c.empty[dest] = (w == 0);
    trace.push_back(c);
    m_dest = 2'(dest);
    for (int i = 0; i < w; i++) begin
      c             = noise(E_WAIT);
      c.empty[dest] = (i == w - 1);
      trace.push_back(c);
    end
    trace.push_back(noise(E_LFD));
    if (abort == 0) begin
      c      = noise(E_LD);
      c.srst = c.srst | (3'b001 << dest);
      trace.push_back(c);
      return;
    end
    if (abort == 1) begin
      c      = noise(E_LD);
      c.rstn = 1'b0;
      trace.push_back(c);
      m_dest = 2'd0;
      return;
    end
    to_parity = 1'b0;
    for (int i = 0; i < len && !to_parity; i++) begin
      if (stall && i == k) begin
        c      = noise(E_LD);
        c.pv   = 1'b1;
        c.full = 1'b1;
        trace.push_back(c);
        for (int j = 0; j < f; j++) begin
          c      = noise(E_FULL);
          c.full = (j != f - 1);
          trace.push_back(c);
        end
        c       = noise(E_LAF);
        c.pdone = (lafx == 2);
        c.lpv   = (lafx == 1);
        trace.push_back(c);
        if (lafx == 2) return;
        if (lafx == 1) to_parity = 1'b1;
      end
      if (!to_parity) begin
        c      = noise(E_LD);
        c.full = 1'b0;
        c.pv   = (i != len - 1);
        trace.push_back(c);
      end
    end
    trace.push_back(noise(E_LP));
    c      = noise(E_CPE);
    c.full = (abort == 2);
    trace.push_back(c);
    if (abort == 2) begin
      c      = noise(E_FULL);
      c.full = 1'b0;
      trace.push_back(c);
      c       = noise(E_LAF);
      c.pdone = 1'b1;
      trace.push_back(c);
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apply(cyc_t c);
    resetn           = c.rstn;
    pkt_valid        = c.pv;
    data_in          = c.din;
    fifo_full        = c.full;
    fifo_empty       = c.empty;
    soft_reset       = c.srst;
    parity_done      = c.pdone;
    low_packet_valid = c.lpv;
  endtask

  function automatic logic [7:0] strobes();
    return {detect_add, lfd_state, ld_state, full_state, laf_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  initial begin
    cyc_t c;
    int   cyc;
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b000; soft_reset = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_strobes", strobes(), E_DEC);
    chk("reset_dest", {6'd0, dest_addr}, 8'd0);
`ifdef CTRL_TIMEOUT_EN
    chk("reset_drop", {7'd0, drop_pkt}, 8'd0);
`endif
    resetn = 1'b1;

    // Directed packets mirroring the main scenarios
    gen_packet(1, 0, 3, 1'b0, 0, 1, 0, 3);   // plain packet to FIFO 1
    gen_idle(1);
    gen_packet(2, 2, 2, 1'b0, 0, 1, 0, 3);   // waits for FIFO 2 to drain
    gen_packet(0, 0, 3, 1'b1, 1, 2, 0, 3);   // full stall, resume payload
    gen_packet(1, 0, 3, 1'b1, 0, 1, 1, 3);   // stall then low_packet_valid
    gen_packet(2, 0, 2, 1'b1, 1, 3, 2, 3);   // stall then parity_done
    gen_packet(0, 0, 2, 1'b0, 0, 1, 0, 0);   // soft reset of selected FIFO
    gen_packet(1, 1, 2, 1'b0, 0, 1, 0, 2);   // full during parity check
    gen_packet(2, 0, 2, 1'b0, 0, 1, 0, 1);   // hard reset mid-payload
    gen_idle(2);

`ifdef CTRL_TIMEOUT_EN
    // Never-draining FIFO 0: 30 held wait cycles, then drop and return to decode
    c          = noise(E_DEC);
    c.srst     = 3'b000;
    c.pv       = 1'b1;
    c.din      = 2'd0;
    c.empty[0] = 1'b0;
    trace.push_back(c);
    m_dest = 2'd0;
    for (int i = 0; i < 30; i++) begin
      c          = noise(E_WAIT);
      c.empty[0] = 1'b0;
      trace.push_back(c);
    end
    c          = noise(E_DEC);
    c.srst     = 3'b000;
    c.pv       = 1'b0;
    c.exp_drop = 1'b1;
    trace.push_back(c);
    gen_idle(1);
`endif

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 4);
      gen_packet($urandom_range(0, 2), $urandom_range(0, 2), len,
                 1'($urandom_range(0, 1)), $urandom_range(0, len - 1),
                 $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 6));
      gen_idle($urandom_range(0, 2));
    end
    gen_idle(1);

    cyc = 0;
    while (trace.size() > 0) begin
      c = trace.pop_front();
      @(negedge clock);
      chk($sformatf("strobes@%0d", cyc), strobes(), c.exp);
      chk($sformatf("dest@%0d", cyc), {6'd0, dest_addr}, {6'd0, c.exp_dest});
`ifdef CTRL_TIMEOUT_EN
      chk($sformatf("drop@%0d", cyc), {7'd0, drop_pkt}, {7'd0, c.exp_drop});
`endif
      apply(c);
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
